exe_stage_pipelined: RTL and testbench

Parametrised successor to the execute stage. It does the same ALU and branch-target work, but adds four things:
- a built-in EXE/MEM output register;
- a valid/ready handshake on both sides;
- a synchronous flush;
- an iterative multi-cycle multiplier (MUL).

It sits between the ID/EX register and the memory stage, and it back-pressures the pipeline while a multiply is busy or the memory stage stalls.

---
 rtl/exe_stage_pipelined.sv | 209 ++++++++++++++++++++
 tb/tb_exe_stage_pipelined.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_pipelined.sv
// Execute stage with ALU, branch-target adder, iterative multiplier and a
// registered EXE/MEM output stage behind a valid/ready handshake.
module exe_stage_pipelined #(
    parameter int unsigned WORD_WIDTH         = 32,
    parameter int unsigned SIGNED_IMM_WIDTH   = 24,
    parameter int unsigned REG_FILE_DEPTH     = 4,
    parameter int unsigned MUL_BITS_PER_CYCLE = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  EX_command,
    input  logic                        mem_read_in,
    input  logic                        mem_write_in,
    input  logic                        WB_en_in,
    input  logic                        B_in,
    input  logic [3:0]                  SR_in,
    input  logic [SIGNED_IMM_WIDTH-1:0] signed_immediate,
    input  logic [REG_FILE_DEPTH-1:0]   dst_in,
    input  logic [WORD_WIDTH-1:0]       pc_in,
    input  logic [WORD_WIDTH-1:0]       val_Rn_in,
    input  logic [WORD_WIDTH-1:0]       val2_in,
    input  logic [WORD_WIDTH-1:0]       val_Rm_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        mem_read_out,
    output logic                        mem_write_out,
    output logic                        WB_en_out,
    output logic                        B_out,
    output logic [3:0]                  SR_out,
    output logic [REG_FILE_DEPTH-1:0]   dst_out,
    output logic [WORD_WIDTH-1:0]       ALU_res,
    output logic [WORD_WIDTH-1:0]       val_Rm_out,
    output logic [WORD_WIDTH-1:0]       branch_address,
    output logic                        busy
);

    localparam int unsigned MSB       = WORD_WIDTH - 1;
    localparam int unsigned MUL_STEPS = WORD_WIDTH / MUL_BITS_PER_CYCLE;
    localparam int unsigned CNT_W     = $clog2(MUL_STEPS + 1);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;

    // Fields of a multiply held while it iterates
    typedef struct packed {
        logic                      mem_read;
        logic                      mem_write;
        logic                      wb_en;
        logic                      b;
        logic [1:0]                cv;
        logic [REG_FILE_DEPTH-1:0] dst;
        logic [WORD_WIDTH-1:0]     val_rm;
        logic [WORD_WIDTH-1:0]     branch_address;
    } pend_t;

    state_t                state;
    pend_t                 pend;
    logic [CNT_W-1:0]      mul_cnt;
    logic [WORD_WIDTH-1:0] mul_acc;
    logic [WORD_WIDTH-1:0] mul_mcand;
    logic [WORD_WIDTH-1:0] mul_mplier;
    logic [WORD_WIDTH-1:0] mul_step;

    logic                  accept;
    logic                  is_mul;
    logic [WORD_WIDTH-1:0] branch_c;
    logic [WORD_WIDTH-1:0] alu_res_c;
    logic [3:0]            alu_sr_c;
    logic [WORD_WIDTH-1:0] op_b;
    logic [WORD_WIDTH:0]   add_full;
    logic                  cin;
    logic                  arith;
    logic                  logical;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign busy     = (state == MUL_BUSY);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (EX_command == OP_MUL);
    assign branch_c = pc_in + WORD_WIDTH'($signed(signed_immediate));

    // Single-cycle ALU and NZCV generation; subtraction is Rn + ~val2 + cin
    always_comb begin
        alu_res_c = '0;
        alu_sr_c  = SR_in;
        op_b      = val2_in;
        cin       = 1'b0;
        arith     = 1'b0;
        logical   = 1'b0;
        add_full  = '0;
        case (EX_command)
            OP_MOV: begin alu_res_c = val2_in;            logical = 1'b1; end
            OP_MVN: begin alu_res_c = ~val2_in;           logical = 1'b1; end
            OP_AND: begin alu_res_c = val_Rn_in & val2_in; logical = 1'b1; end
            OP_ORR: begin alu_res_c = val_Rn_in | val2_in; logical = 1'b1; end
            OP_EOR: begin alu_res_c = val_Rn_in ^ val2_in; logical = 1'b1; end
            OP_ADD: arith = 1'b1;
            OP_ADC: begin arith = 1'b1; cin = SR_in[1]; end
            OP_SUB: begin arith = 1'b1; op_b = ~val2_in; cin = 1'b1; end
            OP_SBC: begin arith = 1'b1; op_b = ~val2_in; cin = SR_in[1]; end
            default: ;
        endcase
        if (arith) begin
            add_full  = {1'b0, val_Rn_in} + {1'b0, op_b} + (WORD_WIDTH + 1)'(cin);
            alu_res_c = add_full[MSB:0];
            alu_sr_c  = {alu_res_c[MSB], alu_res_c == '0, add_full[WORD_WIDTH],
                         (val_Rn_in[MSB] == op_b[MSB]) && (alu_res_c[MSB] != val_Rn_in[MSB])};
        end else if (logical) begin
            alu_sr_c = {alu_res_c[MSB], alu_res_c == '0, SR_in[1:0]};
        end
    end

    // One multiplier digit per cycle, LSB first
    always_comb begin
        mul_step = mul_acc;
        for (int j = 0; j < int'(MUL_BITS_PER_CYCLE); j++) begin
            if (mul_mplier[j]) mul_step = mul_step + (mul_mcand << j);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            pend           <= '0;
            mul_cnt        <= '0;
            mul_acc        <= '0;
            mul_mcand      <= '0;
            mul_mplier     <= '0;
            out_valid      <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            WB_en_out      <= 1'b0;
            B_out          <= 1'b0;
            SR_out         <= '0;
            dst_out        <= '0;
            ALU_res        <= '0;
            val_Rm_out     <= '0;
            branch_address <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            mul_cnt   <= '0;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_mul) begin
                        pend       <= '{mem_read: mem_read_in, mem_write: mem_write_in,
                                        wb_en: WB_en_in, b: B_in, cv: SR_in[1:0],
                                        dst: dst_in, val_rm: val_Rm_in,
                                        branch_address: branch_c};
                        mul_acc    <= '0;
                        mul_mcand  <= val_Rn_in;
                        mul_mplier <= val2_in;
                        mul_cnt    <= CNT_W'(MUL_STEPS);
                        state      <= MUL_BUSY;
                    end else if (accept) begin
                        out_valid      <= 1'b1;
                        ALU_res        <= alu_res_c;
                        SR_out         <= alu_sr_c;
                        dst_out        <= dst_in;
                        mem_read_out   <= mem_read_in;
                        mem_write_out  <= mem_write_in;
                        WB_en_out      <= WB_en_in;
                        B_out          <= B_in;
                        val_Rm_out     <= val_Rm_in;
                        branch_address <= branch_c;
                    end
                end
                MUL_BUSY: begin
                    mul_acc    <= mul_step;
                    mul_mcand  <= mul_mcand << MUL_BITS_PER_CYCLE;
                    mul_mplier <= mul_mplier >> MUL_BITS_PER_CYCLE;
                    mul_cnt    <= mul_cnt - CNT_W'(1);
                    if (mul_cnt == CNT_W'(1)) state <= MUL_DONE;
                end
                MUL_DONE: begin
                    if (!out_valid || out_ready) begin
                        out_valid      <= 1'b1;
                        ALU_res        <= mul_acc;
                        SR_out         <= {mul_acc[MSB], mul_acc == '0, pend.cv};
                        dst_out        <= pend.dst;
                        mem_read_out   <= pend.mem_read;
                        mem_write_out  <= pend.mem_write;
                        WB_en_out      <= pend.wb_en;
                        B_out          <= pend.b;
                        val_Rm_out     <= pend.val_rm;
                        branch_address <= pend.branch_address;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage_pipelined.sv
// Directed bench for exe_stage_pipelined: ALU flags, handshake, multiplier
// latency, flush and asynchronous reset, at default parameters.
module tb_exe_stage_pipelined;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  EX_command;
    logic        mem_read_in, mem_write_in, WB_en_in, B_in;
    logic [3:0]  SR_in;
    logic [23:0] signed_immediate;
    logic [3:0]  dst_in;
    logic [31:0] pc_in, val_Rn_in, val2_in, val_Rm_in;
    logic        out_valid;
    logic        out_ready;
    logic        mem_read_out, mem_write_out, WB_en_out, B_out;
    logic [3:0]  SR_out;
    logic [3:0]  dst_out;
    logic [31:0] ALU_res, val_Rm_out, branch_address;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    exe_stage_pipelined dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .EX_command(EX_command),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .WB_en_in(WB_en_in), .B_in(B_in),
        .SR_in(SR_in), .signed_immediate(signed_immediate), .dst_in(dst_in),
        .pc_in(pc_in), .val_Rn_in(val_Rn_in), .val2_in(val2_in), .val_Rm_in(val_Rm_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .WB_en_out(WB_en_out), .B_out(B_out),
        .SR_out(SR_out), .dst_out(dst_out),
        .ALU_res(ALU_res), .val_Rm_out(val_Rm_out), .branch_address(branch_address),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] rn, input logic [31:0] v2,
                         input logic [3:0] sr);
        EX_command = op;
        val_Rn_in  = rn;
        val2_in    = v2;
        SR_in      = sr;
        in_valid   = 1'b1;
    endtask

    // Single-cycle op: accepted at the next edge, result visible right after it
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rn,
                          input logic [31:0] v2, input logic [3:0] sr,
                          input logic [31:0] exp_res, input logic [3:0] exp_sr);
        drive(op, rn, v2, sr);
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'h1);
        check({tag, "_res"}, ALU_res, exp_res);
        check({tag, "_sr"}, 32'(SR_out), 32'(exp_sr));
    endtask

    // MUL: 8 busy cycles, then one MUL_DONE cycle, then out_valid
    task automatic run_mul(input string tag, input logic [31:0] rn, input logic [31:0] v2,
                           input logic [3:0] sr, input logic [31:0] exp_res,
                           input logic [3:0] exp_sr);
        int busy_cycles;
        drive(4'b1010, rn, v2, sr);
        step();
        in_valid = 1'b0;
        #1;
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'h0);
        check({tag, "_no_early_valid"}, 32'(out_valid), 32'h0);
        busy_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            if (!busy) break;
            busy_cycles++;
            step();
        end
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd8);
        check({tag, "_done_not_valid"}, 32'(out_valid), 32'h0);
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'h1);
        check({tag, "_res"}, ALU_res, exp_res);
        check({tag, "_sr"}, 32'(SR_out), 32'(exp_sr));
    endtask

    initial begin
        int seen;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        EX_command = '0; mem_read_in = 1'b0; mem_write_in = 1'b0; WB_en_in = 1'b0;
        B_in = 1'b0; SR_in = '0; signed_immediate = '0; dst_in = '0;
        pc_in = '0; val_Rn_in = '0; val2_in = '0; val_Rm_in = '0;

        #3;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_alu_res", ALU_res, 32'h0);
        check("rst_sr_out", 32'(SR_out), 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        step();

        // ADD overflow into the sign bit
        dst_in = 4'h3; WB_en_in = 1'b1; mem_read_in = 1'b1;
        drive(4'b0010, 32'h7FFF_FFFF, 32'h1, 4'h0);
        #1;
        check("add_in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check("add_valid", 32'(out_valid), 32'h1);
        check("add_res", ALU_res, 32'h8000_0000);
        check("add_sr", 32'(SR_out), 32'h9);
        check("add_dst", 32'(dst_out), 32'h3);
        check("add_wb", 32'(WB_en_out), 32'h1);
        check("add_mem_read", 32'(mem_read_out), 32'h1);
        WB_en_in = 1'b0; mem_read_in = 1'b0;
        step();
        check("add_drained", 32'(out_valid), 32'h0);

        // SUB to zero, then hold under back-pressure
        out_ready = 1'b0;
        drive(4'b0100, 32'd5, 32'd5, 4'h0);
        step();
        drive(4'b0010, 32'd1, 32'd1, 4'h0);
        #1;
        check("sub_in_ready_bp", 32'(in_ready), 32'h0);
        check("sub_res", ALU_res, 32'h0);
        check("sub_sr", 32'(SR_out), 32'h6);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid", 32'(out_valid), 32'h1);
            check("bp_res", ALU_res, 32'h0);
            check("bp_sr", 32'(SR_out), 32'h6);
            check("bp_in_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'h1);
        check("bp_next_res", ALU_res, 32'h2);
        check("bp_next_sr", 32'(SR_out), 32'h0);

        // Remaining opcodes and flag corners
        run_op("adc",  4'b0011, 32'hFFFF_FFFF, 32'h0,         4'h2, 32'h0,         4'h6);
        run_op("sbc",  4'b0101, 32'd3,         32'd5,         4'h0, 32'hFFFF_FFFD, 4'h8);
        run_op("subv", 4'b0100, 32'h8000_0000, 32'h1,         4'h0, 32'h7FFF_FFFF, 4'h3);
        run_op("mvn",  4'b1001, 32'h0,         32'h0,         4'h3, 32'hFFFF_FFFF, 4'hB);
        run_op("eor",  4'b1000, 32'h0000_F0F0, 32'h0000_F0F0, 4'h0, 32'h0,         4'h4);
        run_op("and",  4'b0110, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'h0, 32'h0F00_0F00, 4'h0);
        run_op("orr",  4'b0111, 32'h1,         32'h8000_0000, 4'h0, 32'h8000_0001, 4'h8);
        run_op("mov",  4'b0001, 32'h0,         32'h5,         4'h0, 32'h5,         4'h0);
        run_op("undef",4'b1111, 32'd5,         32'd5,         4'hA, 32'h0,         4'hA);

        // Branch target with negative and wrapping offsets
        pc_in = 32'h100; signed_immediate = 24'hFF_FFFC; B_in = 1'b1;
        val_Rm_in = 32'hCAFE; mem_write_in = 1'b1;
        run_op("br_neg", 4'b0001, 32'h0, 32'h0, 4'h0, 32'h0, 4'h4);
        check("br_neg_addr", branch_address, 32'hFC);
        check("br_neg_b", 32'(B_out), 32'h1);
        check("br_rm", val_Rm_out, 32'hCAFE);
        check("br_mem_write", 32'(mem_write_out), 32'h1);
        pc_in = 32'hFFFF_FFF0; signed_immediate = 24'h00_0020; B_in = 1'b0; mem_write_in = 1'b0;
        run_op("br_wrap", 4'b0001, 32'h0, 32'h1, 4'h0, 32'h1, 4'h0);
        check("br_wrap_addr", branch_address, 32'h10);
        check("br_wrap_b", 32'(B_out), 32'h0);

        // Multiplier
        dst_in = 4'hA;
        run_mul("mul",     32'h0001_2345, 32'h10,        4'h3, 32'h0012_3450, 4'h3);
        check("mul_dst", 32'(dst_out), 32'hA);
        run_mul("mul_ff",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h0, 32'h1,         4'h0);
        run_mul("mul_z",   32'h8000_0000, 32'h2,         4'h0, 32'h0,         4'h4);
        step();

        // Flush in the 4th busy cycle of a MUL
        drive(4'b1010, 32'd7, 32'd7, 4'h0);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("fl_busy_before", 32'(busy), 32'h1);
        flush = 1'b1;
        drive(4'b0010, 32'd1, 32'd1, 4'h0);
        #1;
        check("fl_in_ready", 32'(in_ready), 32'h0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fl_busy", 32'(busy), 32'h0);
        check("fl_valid", 32'(out_valid), 32'h0);
        check("fl_in_ready_after", 32'(in_ready), 32'h1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("fl_no_result", 32'(seen), 32'h0);

        // Flush of a stalled output register
        out_ready = 1'b0;
        drive(4'b0010, 32'd1, 32'd1, 4'h0);
        step();
        in_valid = 1'b0;
        check("fl_out_valid_set", 32'(out_valid), 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_out_cleared", 32'(out_valid), 32'h0);
        out_ready = 1'b1;

        // Asynchronous reset during a MUL
        drive(4'b1010, 32'd3, 32'd3, 4'h0);
        step();
        in_valid = 1'b0;
        step(); step();
        check("rm_busy_before", 32'(busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rm_busy", 32'(busy), 32'h0);
        check("rm_valid", 32'(out_valid), 32'h0);
        check("rm_res", ALU_res, 32'h0);
        #1 rst = 1'b1;
        step();
        check("rm_in_ready", 32'(in_ready), 32'h1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("rm_no_result", 32'(seen), 32'h0);

        // Asynchronous reset while a result is valid
        pc_in = 32'h200; signed_immediate = 24'h10; B_in = 1'b1;
        run_op("rv", 4'b0010, 32'd4, 32'd4, 4'h0, 32'h8, 4'h0);
        check("rv_addr", branch_address, 32'h210);
        B_in = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rv_valid", 32'(out_valid), 32'h0);
        check("rv_res", ALU_res, 32'h0);
        check("rv_addr_clr", branch_address, 32'h0);
        check("rv_b", 32'(B_out), 32'h0);
        #1 rst = 1'b1;
        step();
        check("rv_in_ready", 32'(in_ready), 32'h1);
        check("rv_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
